// File: rtl/fft_frame_gen_if.sv
// Frame generator control/stream bundle. master = generator, slave = controller/FFT side.
interface fft_frame_gen_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FCNT_W = 16
);
    logic              start;
    logic              stop;
    logic              mode;
    logic [CNT_W-1:0]  frame_len;
    logic [CNT_W-1:0]  gap_len;
    logic              sink_ready;
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic [CNT_W-1:0]  sample_idx;
    logic              busy;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        input  start, stop, mode, frame_len, gap_len, sink_ready,
        output sink_valid, sink_sop, sink_eop, sample_idx, busy, frame_done, frame_cnt
    );

    modport slave (
        output start, stop, mode, frame_len, gap_len, sink_ready,
        input  sink_valid, sink_sop, sink_eop, sample_idx, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/fft_frame_gen.sv
// FFT input frame generator: emits sop/eop-framed sample beats with optional
// inter-frame gaps, single or continuous mode, stop honoured at frame end.
// Optional feature: define FFT_FRAME_GEN_FCNT_EN to build the completed-frame counter.
module fft_frame_gen #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FCNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fft_frame_gen_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic             mode_q, mode_d;
    logic             stop_q, stop_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             fire;
    logic             stop_any;
    logic [CNT_W-1:0] len_new;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            mode_q  <= 1'b0;
            stop_q  <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            mode_q  <= mode_d;
            stop_q  <= stop_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic; flags are precomputed so outputs stay registered
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        mode_d   = mode_q;
        stop_d   = stop_q;
        valid_d  = valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        done_d   = 1'b0;
        fire     = valid_q & bus.sink_ready;
        stop_any = stop_q | bus.stop;
        len_new  = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d   = len_new;
                    gap_d   = bus.gap_len;
                    mode_d  = bus.mode;
                    // A simultaneous stop is kept so the frame ends in IDLE
                    stop_d  = bus.stop;
                    state_d = S_RUN;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = (len_new == CNT_W'(1));
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    stop_d = 1'b1;
                end
                if (fire) begin
                    if (eop_q) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (!mode_q || stop_any) begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                            stop_d  = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d = S_GAP;
                            gcnt_d  = gap_q;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                        end else begin
                            sop_d = 1'b1;
                            eop_d = (len_q == CNT_W'(1));
                        end
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                        sop_d = 1'b0;
                        // next index equals len-1
                        eop_d = ((idx_q + CNT_W'(2)) == len_q);
                    end
                end
            end
            S_GAP: begin
                if (stop_any) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b0;
                end else if (gcnt_q == CNT_W'(1)) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = (len_q == CNT_W'(1));
                end else begin
                    gcnt_d = gcnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.sink_valid = valid_q;
    assign bus.sink_sop   = sop_q;
    assign bus.sink_eop   = eop_q;
    assign bus.sample_idx = idx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

`ifdef FFT_FRAME_GEN_FCNT_EN
    logic [FCNT_W-1:0] fcnt_q;

    // Completed-frame counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (done_q) begin
            fcnt_q <= fcnt_q + FCNT_W'(1);
        end
    end

    assign bus.frame_cnt = fcnt_q;
`else
    assign bus.frame_cnt = FCNT_W'(0);
`endif
endmodule
